// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Logic ops and add/sub finish in one cycle; shifts and multiply iterate in BUSY.
module alu_mc #(
    parameter int DW = 8,
    parameter int SW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [DW-1:0] rd_data,
    input  logic [DW-1:0] rs1_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic [3:0]    flags
);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] DW_CNT = CW'(DW);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [2:0]        op_r;
    logic [CW-1:0]     cnt_r;
    logic [DW-1:0]     sh_r, mplier_r;
    logic [2*DW-1:0]   mcand_r, acc_r;

    logic              accept_s, imm_s, last_s;
    logic [SW-1:0]     k_s;
    logic [DW:0]       add_s, sub_s;
    logic [DW-1:0]     imm_res_s, sh_next_s, fin_res_s;
    logic              imm_c_s, imm_v_s, sh_c_s, fin_c_s;
    logic [2*DW-1:0]   acc_next_s;

    function automatic logic [3:0] mk_flags(input logic [DW-1:0] r, input logic c, input logic v);
        return {r[DW-1], (r == {DW{1'b0}}), c, v};
    endfunction

    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = (state_r == DONE);
    assign accept_s  = in_valid && in_ready;
    assign k_s       = rs1_data[SW-1:0];
    assign add_s     = {1'b0, rd_data} + {1'b0, rs1_data};
    assign sub_s     = {1'b0, rd_data} - {1'b0, rs1_data};
    assign last_s    = (cnt_r == {{(CW-1){1'b0}}, 1'b1});
    // Shifts with a zero amount complete immediately, passing the operand through.
    assign imm_s     = (op <= OP_XOR) || (((op == OP_SHL) || (op == OP_SHR)) && (k_s == {SW{1'b0}}));

    // Single-cycle result path, evaluated on the live request inputs.
    always_comb begin
        imm_res_s = rd_data;
        imm_c_s   = 1'b0;
        imm_v_s   = 1'b0;
        case (op)
            OP_ADD: begin
                imm_res_s = add_s[DW-1:0];
                imm_c_s   = add_s[DW];
                imm_v_s   = (rd_data[DW-1] == rs1_data[DW-1]) && (add_s[DW-1] != rd_data[DW-1]);
            end
            OP_SUB: begin
                imm_res_s = sub_s[DW-1:0];
                imm_c_s   = sub_s[DW];
                imm_v_s   = (rd_data[DW-1] != rs1_data[DW-1]) && (sub_s[DW-1] != rd_data[DW-1]);
            end
            OP_AND:  imm_res_s = rd_data & rs1_data;
            OP_OR:   imm_res_s = rd_data | rs1_data;
            OP_XOR:  imm_res_s = rd_data ^ rs1_data;
            default: imm_res_s = rd_data;
        endcase
    end

    // One iteration step of the shift or shift-add multiply, plus the final result select.
    always_comb begin
        sh_next_s  = sh_r;
        sh_c_s     = 1'b0;
        acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        if (op_r == OP_SHL) begin
            sh_next_s = sh_r << 1;
            sh_c_s    = sh_r[DW-1];
        end else begin
            sh_next_s = sh_r >> 1;
            sh_c_s    = sh_r[0];
        end
        if (op_r == OP_MUL) begin
            fin_res_s = acc_next_s[DW-1:0];
            fin_c_s   = |acc_next_s[2*DW-1:DW];
        end else begin
            fin_res_s = sh_next_s;
            fin_c_s   = sh_c_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = imm_s ? DONE : BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, iteration registers and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 3'd0;
            cnt_r    <= {CW{1'b0}};
            sh_r     <= {DW{1'b0}};
            mplier_r <= {DW{1'b0}};
            mcand_r  <= {(2*DW){1'b0}};
            acc_r    <= {(2*DW){1'b0}};
            result   <= {DW{1'b0}};
            flags    <= 4'd0;
        end else if (accept_s) begin
            op_r     <= op;
            sh_r     <= rd_data;
            mplier_r <= rs1_data;
            mcand_r  <= {{DW{1'b0}}, rd_data};
            acc_r    <= {(2*DW){1'b0}};
            cnt_r    <= (op == OP_MUL) ? DW_CNT : {1'b0, k_s};
            if (imm_s) begin
                result <= imm_res_s;
                flags  <= mk_flags(imm_res_s, imm_c_s, imm_v_s);
            end
        end else if (state_r == BUSY) begin
            sh_r     <= sh_next_s;
            mplier_r <= mplier_r >> 1;
            mcand_r  <= mcand_r << 1;
            acc_r    <= acc_next_s;
            cnt_r    <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            if (last_s) begin
                result <= fin_res_s;
                flags  <= mk_flags(fin_res_s, fin_c_s, 1'b0);
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed table plus randomized model checks and handshake/reset sequences for alu_mc (DW=8).
module tb_alu_mc;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0] op;
    logic [7:0] rd_data, rs1_data, result;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;

    alu_mc #(.DW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rd_data(rd_data), .rs1_data(rs1_data), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] fl;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: integer arithmetic and range tests.
    task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic [3:0] f, output int lat);
        int x, sa, sb;
        logic c, v;
        int k;
        k = int'(b[2:0]);
        sa = (a > 8'd127) ? int'(a) - 256 : int'(a);
        sb = (b > 8'd127) ? int'(b) - 256 : int'(b);
        c = 1'b0; v = 1'b0; lat = 1;
        case (o)
            3'd0: begin x = int'(a) + int'(b); c = (x > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin x = int'(a) - int'(b); c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: x = int'(a & b);
            3'd3: x = int'(a | b);
            3'd4: x = int'(a ^ b);
            3'd5: begin x = int'(a) << k; c = x[8]; lat = (k == 0) ? 1 : k + 1; end
            3'd6: begin x = int'(a) >> k; c = (k == 0) ? 1'b0 : a[k-1]; lat = (k == 0) ? 1 : k + 1; end
            default: begin x = int'(a) * int'(b); c = (x > 255); lat = 9; end
        endcase
        r = x[7:0];
        f = {r[7], (r == 8'd0), c, v};
    endtask

    // Issue one request with out_ready=1; report result, flags and cycles to out_valid.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        in_valid = 1'b1; op = o; rd_data = a; rs1_data = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = ~o; rd_data = ~a; rs1_data = ~b;
        lat = 0;
        r = 8'd0; f = 4'd0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL timeout: op %0d no out_valid after %0d cycles", o, lat);
        end
        r = result; f = flags;
    endtask

    vec_t vecs[15];

    initial begin
        logic [7:0] r, hold_r, ra, rb, er;
        logic [3:0] f, hold_f, ef;
        logic [2:0] ro;
        int lat, el;

        vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001, 1};
        vecs[1]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 4'b1010, 1};
        vecs[2]  = '{3'd5, 8'h81, 8'h03, 8'h08, 4'b0000, 4};
        vecs[3]  = '{3'd6, 8'h81, 8'h01, 8'h40, 4'b0010, 2};
        vecs[4]  = '{3'd5, 8'h81, 8'h08, 8'h81, 4'b1000, 1};
        vecs[5]  = '{3'd7, 8'h10, 8'h10, 8'h00, 4'b0110, 9};
        vecs[6]  = '{3'd7, 8'h0F, 8'h11, 8'hFF, 4'b1000, 9};
        vecs[7]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b0110, 1};
        vecs[8]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 1};
        vecs[9]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1};
        vecs[10] = '{3'd3, 8'h00, 8'h00, 8'h00, 4'b0100, 1};
        vecs[11] = '{3'd4, 8'hAA, 8'h55, 8'hFF, 4'b1000, 1};
        vecs[12] = '{3'd6, 8'h80, 8'h07, 8'h01, 4'b0000, 8};
        vecs[13] = '{3'd5, 8'h01, 8'h07, 8'h80, 4'b1000, 8};
        vecs[14] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 4'b0010, 9};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; rd_data = 8'd0; rs1_data = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", {24'd0, result}, 32'd0);
        chk("reset_flags", {28'd0, flags}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
            chk($sformatf("vec%0d_result", i), {24'd0, r}, {24'd0, vecs[i].res});
            chk($sformatf("vec%0d_flags", i), {28'd0, f}, {28'd0, vecs[i].fl});
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        for (int i = 0; i < 250; i++) begin
            ro = 3'($urandom_range(7, 0));
            ra = 8'($urandom);
            rb = 8'($urandom);
            model(ro, ra, rb, er, ef, el);
            run_op(ro, ra, rb, r, f, lat);
            chk($sformatf("rnd%0d_op%0d_result", i, ro), {24'd0, r}, {24'd0, er});
            chk($sformatf("rnd%0d_op%0d_flags", i, ro), {28'd0, f}, {28'd0, ef});
            chk($sformatf("rnd%0d_op%0d_latency", i, ro), lat, el);
        end

        // Backpressure: hold DONE for 5 cycles while inputs churn.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd0; rd_data = 8'h02; rs1_data = 8'h03;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_enter_done", {31'd0, out_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            op = 3'd1; rd_data = 8'($urandom); rs1_data = 8'($urandom);
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", {24'd0, result}, 32'h05);
            chk("bp_flags", {28'd0, flags}, 32'd0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_result_kept", {24'd0, result}, 32'h05);
        in_valid = 1'b0;

        // Reset three cycles into a multiply.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd7; rd_data = 8'h10; rs1_data = 8'h10;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("rst_discarded", {31'd0, out_valid}, 32'd0);
        end
        run_op(3'd0, 8'h02, 8'h03, r, f, lat);
        chk("post_rst_add_result", {24'd0, r}, 32'h05);
        chk("post_rst_add_latency", lat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
